// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU-op codes (also used by the ALU control block) and datapath mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Moore control word for a state; unlisted fields and unknown states are 0.
    function automatic ctrl_t decode_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = ALUSRCB_FOUR;
            end
            S_DECODE:   c.alu_src_b = ALUSRCB_IMM_SH2;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
            end
            S_ADDI_WB:  c.reg_write = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath; control word is registered from next state.
// Latency 3-5 cycles per instruction; FETCH/MEM_READ/MEM_WRITE hold until mem_ready.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count,
    output logic [3:0]         state_dbg
);

    state_t state;
    state_t nxt;
    ctrl_t  ctrl;
    logic   retire;
    logic   bad_op;
    logic   fetch_go;

    always_comb begin
        nxt    = S_FETCH;
        retire = 1'b0;
        bad_op = 1'b0;
        case (state)
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_RTYPE:     nxt = S_EXECUTE;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDI_EX;
                    default:      bad_op = 1'b1;
                endcase
            end
            // IR still holds the instruction, so opcode remains valid here.
            S_MEM_ADDR:  nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                nxt    = mem_ready ? S_FETCH : S_MEM_WRITE;
                retire = mem_ready;
            end
            S_EXECUTE: nxt = S_R_WB;
            S_ADDI_EX: nxt = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
            default:   nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            ctrl        <= decode_ctrl(S_FETCH);
            instr_count <= '0;
            illegal_op  <= 1'b0;
        end else begin
            state <= nxt;
            ctrl  <= decode_ctrl(nxt);
            if (retire)
                instr_count <= instr_count + COUNT_W'(1);
            if (bad_op)
                illegal_op <= 1'b1;
        end
    end

    // The only Mealy terms: IR/PC load complete with the fetch read, never during reset.
    assign fetch_go = (state == S_FETCH) && mem_ready && !rst;

    assign ir_write      = fetch_go;
    assign pc_write      = ctrl.pc_write | fetch_go;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state_dbg     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instructions modelled as state paths, outputs checked per cycle.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, alu_op, pc_source;
    logic          illegal_op;
    logic [CW-1:0] instr_count;
    logic [3:0]    state_dbg;

    multicycle_control #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: current state, remaining path of the instruction, counters.
    int            exp_state;
    int            path[$];
    logic [CW-1:0] exp_count;
    logic          exp_ill;
    logic [5:0]    cur_op;

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    function automatic logic [15:0] exp_out(int s, logic mr);
        case (s)
            0:  return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00};
            1:  return {10'b0, 2'b11, 2'b00, 2'b00};
            2:  return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            3:  return {2'b00, 1'b1, 1'b1, 12'b0};
            4:  return {6'b0, 1'b1, 1'b0, 1'b1, 7'b0};
            5:  return {2'b00, 1'b1, 1'b0, 1'b1, 11'b0};
            6:  return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            7:  return {7'b0, 1'b1, 1'b1, 7'b0};
            8:  return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            9:  return {1'b1, 13'b0, 2'b10};
            10: return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            11: return {8'b0, 1'b1, 7'b0};
            default: return 16'b0;
        endcase
    endfunction

    wire [15:0] obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    task automatic model_reset();
        exp_state = 0;
        path.delete();
        exp_count = '0;
        exp_ill   = 1'b0;
    endtask

    task automatic model_edge(input logic mr);
        if (exp_state == 0) begin
            if (mr) exp_state = 1;
        end else if (exp_state == 1) begin
            path.delete();
            case (cur_op)
                6'b100011: path = '{2, 3, 4};
                6'b101011: path = '{2, 5};
                6'b000000: path = '{6, 7};
                6'b000100: path = '{8};
                6'b000010: path = '{9};
                6'b001000: path = '{10, 11};
                default:   path.delete();
            endcase
            if (path.size() == 0) begin
                exp_ill   = 1'b1;
                exp_state = 0;
            end else begin
                exp_state = path.pop_front();
            end
        end else if ((exp_state == 3 || exp_state == 5) && !mr) begin
            exp_state = exp_state;
        end else if (path.size() == 0) begin
            exp_count = exp_count + 1'b1;
            exp_state = 0;
        end else begin
            exp_state = path.pop_front();
        end
    endtask

    // One cycle: starts and ends at a falling edge.
    task automatic step(input logic mr);
        mem_ready = mr;
        #1;
        chk("outputs", {16'b0, obs}, {16'b0, exp_out(exp_state, mr)});
        chk("state", {28'b0, state_dbg}, exp_state);
        chk("count", {28'b0, instr_count}, {28'b0, exp_count});
        chk("illegal", {31'b0, illegal_op}, {31'b0, exp_ill});
        @(posedge clk);
        model_edge(mr);
        @(negedge clk);
    endtask

    // Runs one instruction; bit i of stall_mask drops mem_ready in cycle i.
    task automatic run_instr(input logic [5:0] op, input logic [31:0] stall_mask, output int n);
        bit left = 0;
        cur_op = op;
        opcode = op;
        n = 0;
        while (n < 60) begin
            step((n < 32) ? !stall_mask[n] : 1'b1);
            n++;
            if (exp_state != 0) left = 1;
            if (left && exp_state == 0) break;
        end
        if (n >= 60) chk("timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        int n2;
        logic [CW-1:0] c0;
        logic [5:0] ops [7];
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h3f};

        rst = 1'b1;
        opcode = 6'h00;
        mem_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_state", {28'b0, state_dbg}, 32'd0);
        chk("rst_count", {28'b0, instr_count}, 32'd0);
        chk("rst_illegal", {31'b0, illegal_op}, 32'd0);
        chk("rst_outputs", {16'b0, obs}, {16'b0, exp_out(0, 1'b0)});
        @(negedge clk);
        rst = 1'b0;

        run_instr(6'b100011, 32'd0, n);
        chk("lw_latency", 32'(n), 32'd5);
        chk("lw_count", {28'b0, instr_count}, 32'd1);

        run_instr(6'b101011, 32'b111000, n);
        chk("sw_latency", 32'(n), 32'd7);

        c0 = instr_count;
        run_instr(6'b000000, 32'd0, n);
        run_instr(6'b000100, 32'd0, n2);
        chk("r_beq_cycles", 32'(n + n2), 32'd7);
        chk("r_beq_count", {28'b0, instr_count - c0}, 32'd2);

        run_instr(6'b000010, 32'd0, n);
        chk("j_latency", 32'(n), 32'd3);

        c0 = instr_count;
        run_instr(6'b111111, 32'd0, n);
        chk("illegal_latency", 32'(n), 32'd2);
        chk("illegal_flag", {31'b0, illegal_op}, 32'd1);
        chk("illegal_no_retire", {28'b0, instr_count}, {28'b0, c0});
        run_instr(6'b001000, 32'd0, n);
        chk("addi_latency", 32'(n), 32'd4);
        chk("illegal_sticky", {31'b0, illegal_op}, 32'd1);

        // Reset in the middle of a load's MEM_READ stall.
        cur_op = 6'b100011;
        opcode = 6'b100011;
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        chk("pre_rst_state", {28'b0, state_dbg}, 32'd3);
        mem_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_state", {28'b0, state_dbg}, 32'd0);
        chk("mid_rst_mem_read", {31'b0, mem_read}, 32'd1);
        chk("mid_rst_ir_write", {31'b0, ir_write}, 32'd0);
        chk("mid_rst_pc_write", {31'b0, pc_write}, 32'd0);
        chk("mid_rst_i_or_d", {31'b0, i_or_d}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_instr(6'b000010, 32'd0, n);
            if (i == 14) chk("count_15", {28'b0, instr_count}, 32'd15);
        end
        chk("count_wrap", {28'b0, instr_count}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 6)];
            if (op == 6'h3f) op = 6'($urandom);
            run_instr(op, $urandom & $urandom, n);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
